mailbox_snoop: RTL and testbench

//  Passive snooper on the VeeR LSU AXI write channels, sitting between rvtop_wrapper and the sim/console monitor.

---
 rtl/mailbox_snoop.sv | 152 +++++++++++++++
 tb/tb_mailbox_snoop.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mailbox_snoop.sv
// mailbox_snoop: passive observer of the LSU AXI AW/W channels.
// Pairs AW and W handshakes in order. Mailbox bytes are turned into a
// buffered console char stream, plus sticky pass/fail/overflow flags.
// The optional watchdog is enabled by defining MAILBOX_SNOOP_TIMEOUT_EN.
module mailbox_snoop #(
  parameter int          ADDR_W         = 32,
  parameter int          DATA_W         = 64,
  parameter logic [31:0] MBOX_ADDR      = 32'h80F80000,
  parameter int          AW_Q_DEPTH     = 4,
  parameter int          CHAR_DEPTH     = 16,
  parameter int          TIMEOUT_CYCLES = 99_000_000
) (
  input  logic                  core_clk,
  input  logic                  rst_l,
  input  logic                  aw_valid,
  input  logic                  aw_ready,
  input  logic [ADDR_W-1:0]     aw_addr,
  input  logic                  w_valid,
  input  logic                  w_ready,
  input  logic                  w_last,
  input  logic [DATA_W/8-1:0]   w_strb,
  input  logic [DATA_W-1:0]     w_data,
  output logic                  char_valid,
  input  logic                  char_ready,
  output logic [7:0]            char_data,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic                  overflow,
  output logic [15:0]           drop_cnt
);
  localparam int AQW = $clog2(AW_Q_DEPTH);
  localparam int CQW = $clog2(CHAR_DEPTH);

  // AW order queue: one match bit per outstanding write address
  logic [AW_Q_DEPTH-1:0] aw_q;
  logic [AQW:0]          aw_wr, aw_rd;
  logic                  aw_empty, aw_full;

  // console char FIFO
  logic [CHAR_DEPTH-1:0][7:0] c_mem;
  logic [CQW:0]               c_wr, c_rd;
  logic                       c_empty, c_full;

  logic aw_hs, w_hs, aw_match, bypass, aw_pop, aw_push, aw_drop, w_orphan;
  logic w_match, locked, hit, is_char, set_pass, set_fail, c_pop, c_push, c_drop;
  logic [7:0] b;

  assign aw_empty = (aw_wr == aw_rd);
  assign aw_full  = (aw_wr[AQW] != aw_rd[AQW]) && (aw_wr[AQW-1:0] == aw_rd[AQW-1:0]);
  assign c_empty  = (c_wr == c_rd);
  assign c_full   = (c_wr[CQW] != c_rd[CQW]) && (c_wr[CQW-1:0] == c_rd[CQW-1:0]);

  assign aw_hs    = aw_valid & aw_ready;
  assign w_hs     = w_valid & w_ready & w_last;
  assign aw_match = (aw_addr == ADDR_W'(MBOX_ADDR));

  // An AW arriving with its W while nothing is queued is consumed directly
  assign bypass   = w_hs & aw_empty & aw_hs;
  assign aw_pop   = w_hs & ~aw_empty;
  assign aw_push  = aw_hs & ~bypass & (~aw_full | aw_pop);
  assign aw_drop  = aw_hs & ~bypass & aw_full & ~aw_pop;
  assign w_orphan = w_hs & aw_empty & ~aw_hs;
  assign w_match  = aw_pop ? aw_q[aw_rd[AQW-1:0]] : (bypass & aw_match);

  // Classification stops once any terminal flag is set
  assign locked   = pass | fail | timeout;
  assign b        = w_data[7:0];
  assign hit      = w_match & w_strb[0] & ~locked;
  assign is_char  = hit & (b > 8'h06) & (b < 8'h7F);
  assign set_pass = hit & (b == 8'hFF);
  assign set_fail = hit & (b == 8'h01);

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign c_pop    = ~c_empty & char_ready;
  assign c_push   = is_char & (~c_full | c_pop);
  assign c_drop   = is_char & c_full & ~c_pop;

  assign char_valid = ~c_empty;
  assign char_data  = c_empty ? 8'h00 : c_mem[c_rd[CQW-1:0]];

  // AW queue pointers and match bits
  always_ff @(posedge core_clk or negedge rst_l) begin
    if (!rst_l) begin
      aw_q  <= '0;
      aw_wr <= '0;
      aw_rd <= '0;
    end else begin
      if (aw_push) begin
        aw_q[aw_wr[AQW-1:0]] <= aw_match;
        aw_wr                <= aw_wr + 1'b1;
      end
      if (aw_pop) aw_rd <= aw_rd + 1'b1;
    end
  end

  // char FIFO storage; only pointers need reset
  always_ff @(posedge core_clk) begin
    if (c_push) c_mem[c_wr[CQW-1:0]] <= b;
  end

  // char FIFO pointers
  always_ff @(posedge core_clk or negedge rst_l) begin
    if (!rst_l) begin
      c_wr <= '0;
      c_rd <= '0;
    end else begin
      if (c_push) c_wr <= c_wr + 1'b1;
      if (c_pop)  c_rd <= c_rd + 1'b1;
    end
  end

  // sticky status flags and saturating drop counter
  always_ff @(posedge core_clk or negedge rst_l) begin
    if (!rst_l) begin
      pass     <= 1'b0;
      fail     <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (set_pass) pass <= 1'b1;
      if (set_fail) fail <= 1'b1;
      if (aw_drop | w_orphan | c_drop) overflow <= 1'b1;
      if (c_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

`ifdef MAILBOX_SNOOP_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] to_cnt;

  // watchdog: count from reset release, hold at the limit
  always_ff @(posedge core_clk or negedge rst_l) begin
    if (!rst_l) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (to_cnt != TO_LAST) to_cnt <= to_cnt + 32'd1;
      else if (!pass && !fail) timeout <= 1'b1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{w_data[DATA_W-1:8], w_strb[DATA_W/8-1:1]};
`else
  assign timeout = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{w_data[DATA_W-1:8], w_strb[DATA_W/8-1:1], 32'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_mailbox_snoop.sv
// Bench for mailbox_snoop: directed cases with literal expectations, then
// randomized traffic checked every cycle against a queue-based model.
module tb_mailbox_snoop;
  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 64;
  localparam logic [31:0] MBOX   = 32'h80F80000;
  localparam int          AQD    = 4;
  localparam int          CD     = 16;
`ifdef MAILBOX_SNOOP_TIMEOUT_EN
  localparam int          TO     = 100;
`else
  localparam int          TO     = 99_000_000;
`endif

  logic              core_clk = 1'b0;
  logic              rst_l = 1'b0;
  logic              aw_valid = 1'b0, aw_ready = 1'b0;
  logic [ADDR_W-1:0] aw_addr = '0;
  logic              w_valid = 1'b0, w_ready = 1'b0, w_last = 1'b0;
  logic [7:0]        w_strb = '0;
  logic [DATA_W-1:0] w_data = '0;
  logic              char_valid, char_ready = 1'b0;
  logic [7:0]        char_data;
  logic              pass, fail, timeout, overflow;
  logic [15:0]       drop_cnt;

  mailbox_snoop #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MBOX_ADDR(MBOX),
    .AW_Q_DEPTH(AQD), .CHAR_DEPTH(CD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .core_clk(core_clk), .rst_l(rst_l),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last),
    .w_strb(w_strb), .w_data(w_data),
    .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data),
    .pass(pass), .fail(fail), .timeout(timeout), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  always #5 core_clk = ~core_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          mq[$];       // outstanding AW match bits, oldest first
  byte unsigned mc[$];      // console chars, head first
  bit          m_pass, m_fail, m_to, m_ovf;
  int          m_drop, m_cyc;
  bit          e_aw, e_w, e_m, e_have, e_lock;
  byte unsigned e_b;

  always @(posedge core_clk or negedge rst_l) begin
    if (!rst_l) begin
      mq.delete(); mc.delete();
      m_pass = 0; m_fail = 0; m_to = 0; m_ovf = 0; m_drop = 0; m_cyc = 0;
    end else begin
      e_aw   = aw_valid && aw_ready;
      e_w    = w_valid && w_ready && w_last;
      e_lock = m_pass || m_fail || m_to;
      e_have = 0; e_m = 0;
      if (e_w) begin
        if (mq.size() > 0) begin e_m = mq.pop_front(); e_have = 1; end
        else if (e_aw) begin e_m = (aw_addr == MBOX); e_have = 1; e_aw = 0; end
        else m_ovf = 1;
      end
      if (e_aw) begin
        if (mq.size() < AQD) mq.push_back(aw_addr == MBOX);
        else m_ovf = 1;
      end
      if (mc.size() > 0 && char_ready) void'(mc.pop_front());
      e_b = w_data[7:0];
      if (e_have && e_m && w_strb[0] && !e_lock) begin
        if (e_b > 8'h06 && e_b < 8'h7F) begin
          if (mc.size() < CD) mc.push_back(e_b);
          else begin m_ovf = 1; if (m_drop < 16'hFFFF) m_drop++; end
        end else if (e_b == 8'hFF) m_pass = 1;
        else if (e_b == 8'h01) m_fail = 1;
      end
`ifdef MAILBOX_SNOOP_TIMEOUT_EN
      if (m_cyc == TO - 1) begin
        if (!m_pass && !m_fail) m_to = 1;
      end else m_cyc++;
`endif
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge core_clk) begin
    chk("char_valid", char_valid, mc.size() > 0);
    chk("char_data", char_data, (mc.size() > 0) ? mc[0] : 8'h00);
    chk("pass", pass, m_pass);
    chk("fail", fail, m_fail);
    chk("timeout", timeout, m_to);
    chk("overflow", overflow, m_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst_l = 0; aw_valid = 0; w_valid = 0; char_ready = 0;
    @(posedge core_clk); #1;
    rst_l = 1;
  endtask

  task automatic drive(input bit awv, input logic [31:0] a, input bit wv,
                       input bit wl, input logic [7:0] strb, input logic [7:0] d);
    aw_valid = awv; aw_ready = 1; aw_addr = a;
    w_valid = wv; w_ready = 1; w_last = wl; w_strb = strb;
    w_data = {56'h0123456789ABCD, d};
    @(posedge core_clk); #1;
    aw_valid = 0; w_valid = 0;
  endtask

  task automatic pop_one();
    char_ready = 1;
    @(posedge core_clk); #1;
    char_ready = 0;
  endtask

  initial begin
    logic [31:0] r;
    // reset state
    @(posedge core_clk); #1;
    chk("rst char_valid", char_valid, 0);
    chk("rst char_data", char_data, 0);
    chk("rst flags", {pass, fail, timeout, overflow}, 0);
    chk("rst drop_cnt", drop_cnt, 0);
    rst_l = 1;

    // AW mbox then W 'H': char one cycle after the W handshake
    drive(1, MBOX, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 8'h01, 8'h48);
    chk("t1 char_valid", char_valid, 1);
    chk("t1 char_data", char_data, 8'h48);
    pop_one();
    chk("t1 drained", char_valid, 0);

    // same-cycle AW+W 0xFF -> pass; later 0x01 locked out
    do_reset();
    drive(1, MBOX, 1, 1, 8'h01, 8'hFF);
    chk("t2 pass", pass, 1);
    drive(1, MBOX, 1, 1, 8'h01, 8'h01);
    chk("t2 fail locked", fail, 0);
    chk("t2 pass held", pass, 1);

    // non-mailbox address and non-printable byte
    do_reset();
    drive(1, 32'h80000000, 1, 1, 8'h01, 8'h41);
    chk("t3 other addr", char_valid, 0);
    drive(1, MBOX, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 8'h01, 8'h05);
    chk("t3 ctrl byte", {char_valid, pass, fail, overflow}, 0);
    drive(1, MBOX, 1, 1, 8'h00, 8'h41);
    chk("t3 strb0 low", char_valid, 0);

    // fill FIFO past capacity
    do_reset();
    repeat (18) drive(1, MBOX, 1, 1, 8'h01, 8'h61);
    chk("t4 drop_cnt", drop_cnt, 2);
    chk("t4 overflow", overflow, 1);
    for (int i = 0; i < 16; i++) begin
      chk("t4 drain valid", char_valid, 1);
      chk("t4 drain data", char_data, 8'h61);
      pop_one();
    end
    chk("t4 empty", char_valid, 0);

    // AW queue overrun and orphan W
    do_reset();
    repeat (4) drive(1, MBOX, 0, 0, 0, 0);
    chk("t5 no ovf at depth", overflow, 0);
    drive(1, MBOX, 0, 0, 0, 0);
    chk("t5 aw overrun", overflow, 1);
    do_reset();
    drive(0, 0, 1, 1, 8'h01, 8'h48);
    chk("t5 orphan w", overflow, 1);
    chk("t5 orphan no char", char_valid, 0);

`ifdef MAILBOX_SNOOP_TIMEOUT_EN
    do_reset();
    repeat (99) begin @(posedge core_clk); #1; end
    chk("t6 before limit", timeout, 0);
    @(posedge core_clk); #1;
    chk("t6 timeout", timeout, 1);
    rst_l = 0; #1;
    chk("t6 async clear", timeout, 0);
    @(posedge core_clk); #1;
    rst_l = 1;
`endif

    // randomized traffic, model checks every cycle
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        aw_valid = $urandom_range(0, 1);
        aw_ready = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 3);
        aw_addr  = (r < 2) ? MBOX : (r == 2) ? MBOX + 32'd4 : $urandom;
        w_valid  = $urandom_range(0, 1);
        w_ready  = ($urandom_range(0, 3) != 0);
        w_last   = ($urandom_range(0, 3) != 0);
        w_strb   = 8'($urandom);
        w_data   = {$urandom, $urandom};
        r = $urandom_range(0, 127);
        if (r == 0)      w_data[7:0] = 8'hFF;
        else if (r == 1) w_data[7:0] = 8'h01;
        else if (r < 8)  w_data[7:0] = 8'($urandom_range(0, 7));
        else if (r < 16) w_data[7:0] = 8'($urandom);
        else             w_data[7:0] = 8'($urandom_range(8'h20, 8'h7E));
        char_ready = ($urandom_range(0, 2) == 0);
        @(posedge core_clk); #1;
      end
    end
    aw_valid = 0; w_valid = 0;
    @(posedge core_clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
